// File: rtl/l0_cache_tag_array.sv
`default_nettype none
// ============================================================================
//  Module   : l0_cache_tag_array
//  Purpose  : N-way set-associative tag + per-byte-valid store for the L0
//             data cache. Loads get a registered hit/way result one cycle
//             after the request. Stores update valid bits on a tag match or
//             allocate a victim way (lowest empty way, else round-robin).
//             A flush sequencer clears one set per cycle.
//  Ports    : i_clk, i_rst_n (async, active low)
//             i_lookup_valid/addr/size -> o_hit_valid, o_hit, o_hit_way
//             i_write_valid/addr/byte_en -> o_write_way
//             i_flush_req -> o_flush_busy
//             o_hit_count / o_miss_count (statistics)
//  Options  : define L0_CACHE_STATS_EN to build the saturating hit/miss
//             counters; otherwise both counter outputs are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module l0_cache_tag_array #(
    parameter int          XLEN                = 32,
    parameter int          NUM_SETS            = 64,
    parameter int          NUM_WAYS            = 2,
    parameter int          MEM_BYTE_ADDR_WIDTH = 16,
    parameter logic [31:0] MMIO_ADDR           = 32'h4000_0000,
    localparam int         c_way_w             = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_lookup_valid,
    input  logic [XLEN-1:0]     i_lookup_addr,
    input  logic [1:0]          i_lookup_size,
    output logic                o_hit_valid,
    output logic                o_hit,
    output logic [c_way_w-1:0]  o_hit_way,
    input  logic                i_write_valid,
    input  logic [XLEN-1:0]     i_write_addr,
    input  logic [XLEN/8-1:0]   i_write_byte_en,
    output logic [c_way_w-1:0]  o_write_way,
    input  logic                i_flush_req,
    output logic                o_flush_busy,
    output logic [31:0]         o_hit_count,
    output logic [31:0]         o_miss_count
);

    localparam int c_nb      = XLEN / 8;
    localparam int c_off_w   = $clog2(c_nb);
    localparam int c_idx_w   = $clog2(NUM_SETS);
    localparam int c_tag_lsb = c_off_w + c_idx_w;
    localparam int c_tag_w   = MEM_BYTE_ADDR_WIDTH - c_tag_lsb;
    localparam logic [XLEN-1:0] c_mmio = XLEN'(MMIO_ADDR);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_idx_w-1:0]   r_flush_idx, w_flush_idx_nxt;

    // Storage: tags are never reset; a way only counts when it has valid bytes.
    logic [c_tag_w-1:0]   r_tag   [NUM_SETS][NUM_WAYS];
    logic [c_nb-1:0]      r_valid [NUM_SETS][NUM_WAYS];
    logic [c_way_w-1:0]   r_rr    [NUM_SETS];

    // ---------------- lookup path ----------------
    logic [c_off_w-1:0]   w_lk_off;
    logic [c_idx_w-1:0]   w_lk_idx;
    logic [c_tag_w-1:0]   w_lk_tag;
    logic [3:0]           w_lk_nbytes;
    logic [c_nb-1:0]      w_lk_mask;
    logic                 w_lk_forced_miss;
    logic                 w_lk_hit;
    logic [c_way_w-1:0]   w_lk_way;

    assign w_lk_off    = i_lookup_addr[c_off_w-1:0];
    assign w_lk_idx    = i_lookup_addr[c_tag_lsb-1:c_off_w];
    assign w_lk_tag    = i_lookup_addr[MEM_BYTE_ADDR_WIDTH-1:c_tag_lsb];
    assign w_lk_nbytes = 4'd1 << i_lookup_size;

    // Accesses wider than the data path (dword on XLEN=32) and misaligned
    // accesses are never reported as hits.
    assign w_lk_forced_miss = (i_lookup_addr >= c_mmio)
                           || ((int'(w_lk_off) & (int'(w_lk_nbytes) - 1)) != 0)
                           || (int'(w_lk_nbytes) > c_nb)
                           || (r_state == ST_FLUSH);

    always_comb begin
        w_lk_mask = '0;
        for (int b = 0; b < c_nb; b++) begin
            w_lk_mask[b] = (b >= int'(w_lk_off)) && (b < int'(w_lk_off) + int'(w_lk_nbytes));
        end
    end

    // Descending scan so the lowest matching way wins.
    always_comb begin
        w_lk_hit = 1'b0;
        w_lk_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if ((r_tag[w_lk_idx][w] == w_lk_tag)
                && ((r_valid[w_lk_idx][w] & w_lk_mask) == w_lk_mask)) begin
                w_lk_hit = 1'b1;
                w_lk_way = c_way_w'(w);
            end
        end
    end

    // ---------------- write / allocate path ----------------
    logic [c_idx_w-1:0]   w_wr_idx;
    logic [c_tag_w-1:0]   w_wr_tag;
    logic                 w_wr_en;
    logic                 w_wr_hit;
    logic [c_way_w-1:0]   w_wr_hit_way;
    logic                 w_wr_free;
    logic [c_way_w-1:0]   w_wr_free_way;
    logic [c_way_w-1:0]   w_victim;
    logic                 w_rr_adv;
    logic [c_way_w-1:0]   w_rr_nxt;

    assign w_wr_idx = i_write_addr[c_tag_lsb-1:c_off_w];
    assign w_wr_tag = i_write_addr[MEM_BYTE_ADDR_WIDTH-1:c_tag_lsb];
    assign w_wr_en  = i_write_valid && (|i_write_byte_en)
                   && (i_write_addr < c_mmio) && (r_state == ST_IDLE);

    always_comb begin
        w_wr_hit      = 1'b0;
        w_wr_hit_way  = '0;
        w_wr_free     = 1'b0;
        w_wr_free_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if ((r_tag[w_wr_idx][w] == w_wr_tag) && (|r_valid[w_wr_idx][w])) begin
                w_wr_hit     = 1'b1;
                w_wr_hit_way = c_way_w'(w);
            end
            if (r_valid[w_wr_idx][w] == '0) begin
                w_wr_free     = 1'b1;
                w_wr_free_way = c_way_w'(w);
            end
        end
    end

    // The RR pointer only moves when it actually chose the victim.
    assign w_rr_adv = !w_wr_hit && !w_wr_free;
    assign w_victim = w_wr_hit  ? w_wr_hit_way :
                      w_wr_free ? w_wr_free_way : r_rr[w_wr_idx];
    assign w_rr_nxt = (r_rr[w_wr_idx] == c_way_w'(NUM_WAYS - 1)) ? '0
                                                                 : r_rr[w_wr_idx] + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    r_valid[s][w] <= '0;
                end
                r_rr[s] <= '0;
            end
        end else if (r_state == ST_FLUSH) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                r_valid[r_flush_idx][w] <= '0;
            end
            r_rr[r_flush_idx] <= '0;
        end else if (w_wr_en) begin
            r_valid[w_wr_idx][w_victim] <= w_wr_hit ? (r_valid[w_wr_idx][w_victim] | i_write_byte_en)
                                                    : i_write_byte_en;
            if (w_rr_adv) begin
                r_rr[w_wr_idx] <= w_rr_nxt;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en && !w_wr_hit) begin
            r_tag[w_wr_idx][w_victim] <= w_wr_tag;
        end
    end

    // ---------------- registered outputs ----------------
    logic               r_hit_valid;
    logic               r_hit;
    logic [c_way_w-1:0] r_hit_way;
    logic [c_way_w-1:0] r_write_way;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hit_valid <= 1'b0;
            r_hit       <= 1'b0;
            r_hit_way   <= '0;
            r_write_way <= '0;
        end else begin
            r_hit_valid <= i_lookup_valid;
            r_hit       <= i_lookup_valid && !w_lk_forced_miss && w_lk_hit;
            r_hit_way   <= (i_lookup_valid && !w_lk_forced_miss && w_lk_hit) ? w_lk_way : '0;
            if (w_wr_en) begin
                r_write_way <= w_victim;
            end
        end
    end

    assign o_hit_valid  = r_hit_valid;
    assign o_hit        = r_hit;
    assign o_hit_way    = r_hit_way;
    assign o_write_way  = r_write_way;
    assign o_flush_busy = (r_state == ST_FLUSH);

    // ---------------- flush sequencer ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_flush_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_idx <= w_flush_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_idx_nxt = r_flush_idx;
        case (r_state)
            ST_IDLE: begin
                if (i_flush_req) begin
                    w_state_nxt     = ST_FLUSH;
                    w_flush_idx_nxt = '0;
                end
            end
            ST_FLUSH: begin
                w_flush_idx_nxt = r_flush_idx + 1'b1;
                if (r_flush_idx == c_idx_w'(NUM_SETS - 1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- statistics ----------------
`ifdef L0_CACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (r_hit_valid) begin
            if (r_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (!r_hit && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign o_hit_count  = r_hit_count;
    assign o_miss_count = r_miss_count;
`else
    assign o_hit_count  = 32'd0;
    assign o_miss_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_l0_cache_tag_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l0_cache_tag_array
//  Purpose  : Directed self-checking bench for l0_cache_tag_array. One
//             instance at XLEN=32 (2 ways, 64 sets) and one at XLEN=64.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_l0_cache_tag_array;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_addr = '0;
    logic [1:0]  lookup_size = '0;
    logic        hit_valid, hit;
    logic [0:0]  hit_way;
    logic        write_valid = 1'b0;
    logic [31:0] write_addr = '0;
    logic [3:0]  write_be = '0;
    logic [0:0]  write_way;
    logic        flush_req = 1'b0;
    logic        flush_busy;
    logic [31:0] hit_count, miss_count;

    logic        lookup_valid64 = 1'b0;
    logic [63:0] lookup_addr64 = '0;
    logic [1:0]  lookup_size64 = '0;
    logic        hit_valid64, hit64;
    logic [0:0]  hit_way64;
    logic        write_valid64 = 1'b0;
    logic [63:0] write_addr64 = '0;
    logic [7:0]  write_be64 = '0;
    logic [0:0]  write_way64;
    logic        flush_req64 = 1'b0;
    logic        flush_busy64;
    logic [31:0] hit_count64, miss_count64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    l0_cache_tag_array #(.XLEN(32), .NUM_SETS(64), .NUM_WAYS(2), .MEM_BYTE_ADDR_WIDTH(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_lookup_valid(lookup_valid), .i_lookup_addr(lookup_addr), .i_lookup_size(lookup_size),
        .o_hit_valid(hit_valid), .o_hit(hit), .o_hit_way(hit_way),
        .i_write_valid(write_valid), .i_write_addr(write_addr), .i_write_byte_en(write_be),
        .o_write_way(write_way), .i_flush_req(flush_req), .o_flush_busy(flush_busy),
        .o_hit_count(hit_count), .o_miss_count(miss_count));

    l0_cache_tag_array #(.XLEN(64), .NUM_SETS(64), .NUM_WAYS(2), .MEM_BYTE_ADDR_WIDTH(16)) dut64 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_lookup_valid(lookup_valid64), .i_lookup_addr(lookup_addr64), .i_lookup_size(lookup_size64),
        .o_hit_valid(hit_valid64), .o_hit(hit64), .o_hit_way(hit_way64),
        .i_write_valid(write_valid64), .i_write_addr(write_addr64), .i_write_byte_en(write_be64),
        .o_write_way(write_way64), .i_flush_req(flush_req64), .o_flush_busy(flush_busy64),
        .o_hit_count(hit_count64), .o_miss_count(miss_count64));

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        lookup_valid = 0; write_valid = 0; flush_req = 0;
        lookup_valid64 = 0; write_valid64 = 0;
        rst_n = 0;
        step();
        rst_n = 1;
        step();
    endtask

    task automatic do_lookup(input logic [31:0] a, input logic [1:0] s,
                             output logic hv, output logic h, output logic [0:0] w);
        lookup_valid = 1; lookup_addr = a; lookup_size = s;
        step();
        hv = hit_valid; h = hit; w = hit_way;
        lookup_valid = 0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] be, output logic [0:0] w);
        write_valid = 1; write_addr = a; write_be = be;
        step();
        w = write_way;
        write_valid = 0;
    endtask

    task automatic do_lookup64(input logic [63:0] a, input logic [1:0] s,
                               output logic hv, output logic h, output logic [0:0] w);
        lookup_valid64 = 1; lookup_addr64 = a; lookup_size64 = s;
        step();
        hv = hit_valid64; h = hit64; w = hit_way64;
        lookup_valid64 = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        lookup_valid = 1; lookup_addr = 32'h1234; lookup_size = 2'b10;
        step(); step();
        checks++; if (hit_valid !== 1'b0) begin errors++; $display("FAIL reset hit_valid: got %b want 0", hit_valid); end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset hit: got %b want 0", hit); end
        checks++; if (hit_way !== 1'b0) begin errors++; $display("FAIL reset hit_way: got %0d want 0", hit_way); end
        checks++; if (write_way !== 1'b0) begin errors++; $display("FAIL reset write_way: got %0d want 0", write_way); end
        checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL reset flush_busy: got %b want 0", flush_busy); end
        checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("FAIL reset counters: got %0d/%0d want 0/0", hit_count, miss_count); end
        lookup_valid = 0;
        rst_n = 1;
        step();
        checks++; if (hit_valid !== 1'b0) begin errors++; $display("FAIL idle hit_valid: got %b want 0", hit_valid); end
    endtask

    task automatic test_basic_hit();
        logic hv, h; logic [0:0] w;
        apply_reset();
        do_write(32'h0000_1234, 4'b1111, w);
        checks++; if (w !== 1'b0) begin errors++; $display("FAIL basic write_way: got %0d want 0", w); end
        do_lookup(32'h0000_1234, 2'b10, hv, h, w);
        checks++; if (hv !== 1'b1 || h !== 1'b1 || w !== 1'b0) begin errors++; $display("FAIL basic lookup: got hv=%b hit=%b way=%0d want 1 1 0", hv, h, w); end
        step();
        checks++; if (hit_valid !== 1'b0 || hit !== 1'b0) begin errors++; $display("FAIL no-request: got hv=%b hit=%b want 0 0", hit_valid, hit); end
    endtask

    task automatic test_partial_valid();
        logic hv, h; logic [0:0] w;
        apply_reset();
        do_write(32'h0000_1234, 4'b0011, w);
        do_lookup(32'h0000_1236, 2'b01, hv, h, w);
        checks++; if (hv !== 1'b1 || h !== 1'b0) begin errors++; $display("FAIL half upper invalid: got hv=%b hit=%b want 1 0", hv, h); end
        do_lookup(32'h0000_1235, 2'b00, hv, h, w);
        checks++; if (h !== 1'b1 || w !== 1'b0) begin errors++; $display("FAIL byte 0x1235: got hit=%b way=%0d want 1 0", h, w); end
        do_lookup(32'h0000_1234, 2'b10, hv, h, w);
        checks++; if (h !== 1'b0) begin errors++; $display("FAIL word partial: got hit=%b want 0", h); end
        do_write(32'h0000_1234, 4'b1100, w);
        checks++; if (w !== 1'b0) begin errors++; $display("FAIL merge write_way: got %0d want 0", w); end
        do_lookup(32'h0000_1234, 2'b10, hv, h, w);
        checks++; if (h !== 1'b1 || w !== 1'b0) begin errors++; $display("FAIL word merged: got hit=%b way=%0d want 1 0", h, w); end
        do_lookup(32'h0000_1235, 2'b01, hv, h, w);
        checks++; if (h !== 1'b0) begin errors++; $display("FAIL misaligned half: got hit=%b want 0", h); end
        do_lookup(32'h0000_1236, 2'b10, hv, h, w);
        checks++; if (h !== 1'b0) begin errors++; $display("FAIL misaligned word: got hit=%b want 0", h); end
        do_lookup(32'h0000_1234, 2'b11, hv, h, w);
        checks++; if (hv !== 1'b1 || h !== 1'b0) begin errors++; $display("FAIL dword on xlen32: got hv=%b hit=%b want 1 0", hv, h); end
    endtask

    task automatic test_replacement();
        logic hv, h; logic [0:0] w;
        apply_reset();
        do_write(32'h0134, 4'hF, w);
        checks++; if (w !== 1'b0) begin errors++; $display("FAIL rr first: got way %0d want 0", w); end
        do_write(32'h0234, 4'hF, w);
        checks++; if (w !== 1'b1) begin errors++; $display("FAIL rr second: got way %0d want 1", w); end
        do_write(32'h0334, 4'hF, w);
        checks++; if (w !== 1'b0) begin errors++; $display("FAIL rr third: got way %0d want 0", w); end
        do_lookup(32'h0134, 2'b10, hv, h, w);
        checks++; if (h !== 1'b0) begin errors++; $display("FAIL evicted 0x0134: got hit=%b want 0", h); end
        do_lookup(32'h0234, 2'b10, hv, h, w);
        checks++; if (h !== 1'b1 || w !== 1'b1) begin errors++; $display("FAIL 0x0234: got hit=%b way=%0d want 1 1", h, w); end
        do_lookup(32'h0334, 2'b10, hv, h, w);
        checks++; if (h !== 1'b1 || w !== 1'b0) begin errors++; $display("FAIL 0x0334: got hit=%b way=%0d want 1 0", h, w); end
        // Ignored writes: zero byte enable and MMIO must not evict anything.
        do_write(32'h0434, 4'h0, w);
        do_lookup(32'h0234, 2'b10, hv, h, w);
        checks++; if (h !== 1'b1 || w !== 1'b1) begin errors++; $display("FAIL be=0 write evicted: got hit=%b way=%0d want 1 1", h, w); end
        do_write(32'h4000_0434, 4'hF, w);
        do_lookup(32'h0234, 2'b10, hv, h, w);
        checks++; if (h !== 1'b1 || w !== 1'b1) begin errors++; $display("FAIL mmio write evicted: got hit=%b way=%0d want 1 1", h, w); end
        do_write(32'h0434, 4'hF, w);
        checks++; if (w !== 1'b1) begin errors++; $display("FAIL rr fourth: got way %0d want 1", w); end
        do_write(32'h0134, 4'hF, w);
        checks++; if (w !== 1'b0) begin errors++; $display("FAIL rr fifth: got way %0d want 0", w); end
        do_lookup(32'h0434, 2'b10, hv, h, w);
        checks++; if (h !== 1'b1 || w !== 1'b1) begin errors++; $display("FAIL 0x0434: got hit=%b way=%0d want 1 1", h, w); end
        do_lookup(32'h0334, 2'b10, hv, h, w);
        checks++; if (h !== 1'b0) begin errors++; $display("FAIL evicted 0x0334: got hit=%b want 0", h); end
    endtask

    task automatic test_mmio();
        logic hv, h; logic [0:0] w;
        apply_reset();
        do_write(32'h0000_0000, 4'hF, w);
        do_write(32'h0000_0100, 4'hF, w);
        checks++; if (w !== 1'b1) begin errors++; $display("FAIL mmio setup way: got %0d want 1", w); end
        do_lookup(32'h4000_0000, 2'b10, hv, h, w);
        checks++; if (hv !== 1'b1 || h !== 1'b0) begin errors++; $display("FAIL mmio lookup: got hv=%b hit=%b want 1 0", hv, h); end
        do_lookup(32'h0000_0000, 2'b10, hv, h, w);
        checks++; if (h !== 1'b1 || w !== 1'b0) begin errors++; $display("FAIL cacheable alias: got hit=%b way=%0d want 1 0", h, w); end
        do_write(32'h4000_0010, 4'hF, w);
        checks++; if (w !== 1'b1) begin errors++; $display("FAIL mmio write_way moved: got %0d want 1", w); end
        do_lookup(32'h0000_0010, 2'b10, hv, h, w);
        checks++; if (h !== 1'b0) begin errors++; $display("FAIL mmio write allocated: got hit=%b want 0", h); end
    endtask

    task automatic test_back_to_back();
        logic hv, h; logic [0:0] w;
        apply_reset();
        lookup_valid = 1; lookup_addr = 32'h1234; lookup_size = 2'b10;
        write_valid = 1; write_addr = 32'h1234; write_be = 4'hF;
        step();
        write_valid = 0;
        checks++; if (hit_valid !== 1'b1 || hit !== 1'b0) begin errors++; $display("FAIL same-cycle lookup: got hv=%b hit=%b want 1 0", hit_valid, hit); end
        step();
        checks++; if (hit_valid !== 1'b1 || hit !== 1'b1) begin errors++; $display("FAIL next-cycle lookup: got hv=%b hit=%b want 1 1", hit_valid, hit); end
        lookup_valid = 0;
        do_lookup(32'h1235, 2'b00, hv, h, w);
        checks++; if (h !== 1'b1) begin errors++; $display("FAIL back-to-back byte: got hit=%b want 1", h); end
    endtask

    task automatic test_flush();
        logic hv, h; logic [0:0] w;
        logic [31:0] addrs [4];
        int k;
        int busy_cycles;
        logic mid_hv, mid_hit;
        addrs[0] = 32'h0000; addrs[1] = 32'h0104; addrs[2] = 32'h0208; addrs[3] = 32'h030C;
        apply_reset();
        for (int i = 0; i < 4; i++) do_write(addrs[i], 4'hF, w);
        do_lookup(addrs[2], 2'b10, hv, h, w);
        checks++; if (h !== 1'b1) begin errors++; $display("FAIL pre-flush hit: got %b want 1", h); end
        flush_req = 1;
        step();
        flush_req = 0;
        busy_cycles = 0; k = 0; mid_hv = 0; mid_hit = 1;
        while (flush_busy === 1'b1 && k < 200) begin
            busy_cycles++;
            flush_req    = (k == 10);
            lookup_valid = (k == 20); lookup_addr = addrs[0]; lookup_size = 2'b10;
            write_valid  = (k == 30); write_addr = 32'h0134; write_be = 4'hF;
            step();
            k++;
            if (k == 21) begin mid_hv = hit_valid; mid_hit = hit; end
        end
        flush_req = 0; lookup_valid = 0; write_valid = 0;
        checks++; if (busy_cycles != 64) begin errors++; $display("FAIL flush busy length: got %0d want 64", busy_cycles); end
        checks++; if (mid_hv !== 1'b1 || mid_hit !== 1'b0) begin errors++; $display("FAIL lookup during flush: got hv=%b hit=%b want 1 0", mid_hv, mid_hit); end
        for (int i = 0; i < 4; i++) begin
            do_lookup(addrs[i], 2'b10, hv, h, w);
            checks++; if (hv !== 1'b1 || h !== 1'b0) begin errors++; $display("FAIL post-flush set %0d: got hv=%b hit=%b want 1 0", i, hv, h); end
        end
        do_lookup(32'h0134, 2'b10, hv, h, w);
        checks++; if (h !== 1'b0) begin errors++; $display("FAIL write during flush: got hit=%b want 0", h); end
        do_write(32'h0000, 4'hF, w);
        do_lookup(32'h0000, 2'b10, hv, h, w);
        checks++; if (h !== 1'b1 || w !== 1'b0) begin errors++; $display("FAIL refill after flush: got hit=%b way=%0d want 1 0", h, w); end
    endtask

    task automatic test_xlen64();
        logic hv, h; logic [0:0] w;
        logic [31:0] exp_hits, exp_miss;
        apply_reset();
        write_valid64 = 1; write_addr64 = 64'h1238; write_be64 = 8'hFF;
        step();
        write_valid64 = 0;
        checks++; if (write_way64 !== 1'b0) begin errors++; $display("FAIL x64 write_way: got %0d want 0", write_way64); end
        do_lookup64(64'h1238, 2'b11, hv, h, w);
        checks++; if (hv !== 1'b1 || h !== 1'b1 || w !== 1'b0) begin errors++; $display("FAIL x64 dword: got hv=%b hit=%b way=%0d want 1 1 0", hv, h, w); end
        do_lookup64(64'h123C, 2'b11, hv, h, w);
        checks++; if (hv !== 1'b1 || h !== 1'b0) begin errors++; $display("FAIL x64 misaligned dword: got hv=%b hit=%b want 1 0", hv, h); end
        step();
`ifdef L0_CACHE_STATS_EN
        exp_hits = 32'd1; exp_miss = 32'd1;
`else
        exp_hits = 32'd0; exp_miss = 32'd0;
`endif
        checks++; if (hit_count64 !== exp_hits) begin errors++; $display("FAIL x64 hit_count: got %0d want %0d", hit_count64, exp_hits); end
        checks++; if (miss_count64 !== exp_miss) begin errors++; $display("FAIL x64 miss_count: got %0d want %0d", miss_count64, exp_miss); end
        do_lookup64(64'h123C, 2'b10, hv, h, w);
        checks++; if (h !== 1'b1) begin errors++; $display("FAIL x64 upper word: got hit=%b want 1", h); end
    endtask

    initial begin
        test_reset();
        test_basic_hit();
        test_partial_valid();
        test_replacement();
        test_mmio();
        test_back_to_back();
        test_flush();
        test_xlen64();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
